// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check: GMII receive framer with Ethernet FCS check and FCS stripping.
//
// Finds the preamble/SFD, runs CRC32 over every post-SFD byte including the FCS, and
// delays the byte stream by five entries so the four FCS bytes can be dropped. Payload
// bytes leave with SOF/EOF markers. A one-cycle status strobe follows each frame.
//
// Ports:
//   Clk, Reset           GMII RX clock; asynchronous active-high reset
//   gmii_rx_dv/er/rxd    GMII receive interface (captured into an input register)
//   m_valid/m_data       payload byte stream, one strobe per byte, no backpressure
//   m_sof/m_eof          first/last payload byte markers (qualified by m_valid)
//   frame_done           end-of-frame strobe; the status outputs below update with it
//   crc_ok, len_ok       residue check and MIN_LEN <= N <= MAX_LEN (N = post-SFD bytes)
//   rx_err               gmii_rx_er was seen during frame data
//   frame_good           crc_ok & len_ok & ~rx_err
//   frame_len            N-4 (payload length), 0 when N < 4
module eth_rx_fcs_check #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        m_valid,
    output logic [7:0]  m_data,
    output logic        m_sof,
    output logic        m_eof,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        len_ok,
    output logic        rx_err,
    output logic        frame_good,
    output logic [15:0] frame_len
);

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

    // Residue of the MSB-first CRC register after a frame with a correct FCS.
    localparam logic [31:0] CrcResidue = 32'hC704DD7B;

    state_e          state_q;
    logic            dv_q, er_q;
    logic [7:0]      rxd_q;
    logic [31:0]     crc_q, crc_d;
    logic [4:0][7:0] buf_q;      // [0] newest, [4] oldest
    logic [15:0]     cnt_q;
    logic            err_q;

    logic            m_valid_q, m_sof_q, m_eof_q, frame_done_q;
    logic [7:0]      m_data_q;
    logic            crc_ok_q, len_ok_q, rx_err_q, frame_good_q;
    logic [15:0]     frame_len_q;

    logic            len_ok_d;

    // Wire-order LSB-first data into an MSB-first shift register with poly 04C11DB7.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    always_comb begin
        crc_d    = crc32_byte(crc_q, rxd_q);
        len_ok_d = ({16'd0, cnt_q} >= MIN_LEN) && ({16'd0, cnt_q} <= MAX_LEN);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            dv_q         <= 1'b0;
            er_q         <= 1'b0;
            rxd_q        <= 8'd0;
            crc_q        <= 32'hFFFFFFFF;
            buf_q        <= '0;
            cnt_q        <= 16'd0;
            err_q        <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'd0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            len_ok_q     <= 1'b0;
            rx_err_q     <= 1'b0;
            frame_good_q <= 1'b0;
            frame_len_q  <= 16'd0;
        end else begin
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
            rxd_q <= gmii_rxd;

            // Strobes default low; m_* are forced to zero when not valid.
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'd0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (dv_q) begin
                        state_q <= (rxd_q == 8'h55) ? StPreamble : StDrop;
                    end
                end
                StPreamble: begin
                    if (!dv_q) begin
                        state_q <= StIdle;
                    end else if (rxd_q == 8'hD5) begin
                        state_q <= StData;
                        crc_q   <= 32'hFFFFFFFF;
                        cnt_q   <= 16'd0;
                        err_q   <= 1'b0;
                    end else if (rxd_q != 8'h55) begin
                        state_q <= StDrop;
                    end
                end
                StData: begin
                    if (dv_q) begin
                        crc_q <= crc_d;
                        buf_q <= {buf_q[3:0], rxd_q};
                        cnt_q <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        if (er_q) begin
                            err_q <= 1'b1;
                        end
                        // Five bytes already buffered: the oldest cannot be FCS.
                        if (cnt_q >= 16'd5) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= buf_q[4];
                            m_sof_q   <= (cnt_q == 16'd5);
                        end
                    end else begin
                        state_q <= StIdle;
                        if (cnt_q >= 16'd5) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= buf_q[4];
                            m_sof_q   <= (cnt_q == 16'd5);
                            m_eof_q   <= 1'b1;
                        end
                        frame_done_q <= 1'b1;
                        crc_ok_q     <= (crc_q == CrcResidue);
                        len_ok_q     <= len_ok_d;
                        rx_err_q     <= err_q;
                        frame_good_q <= (crc_q == CrcResidue) && len_ok_d && !err_q;
                        frame_len_q  <= (cnt_q < 16'd4) ? 16'd0 : cnt_q - 16'd4;
                    end
                end
                StDrop: begin
                    if (!dv_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = m_sof_q;
    assign m_eof      = m_eof_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign len_ok     = len_ok_q;
    assign rx_err     = rx_err_q;
    assign frame_good = frame_good_q;
    assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Testbench for eth_rx_fcs_check: directed frames, scoreboard of expected payload bytes
// and per-frame status, checked as the DUT emits them. A second instance with
// MIN_LEN=13 checks frame_good on short frames.
module tb_eth_rx_fcs_check;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        dv, er;
    logic [7:0]  rxd;

    logic        m_valid, m_sof, m_eof, frame_done, crc_ok, len_ok, rx_err, frame_good;
    logic [7:0]  m_data;
    logic [15:0] frame_len;

    logic        v13, sof13, eof13, fd13, crc13, len13, err13, good13;
    logic [7:0]  d13;
    logic [15:0] flen13;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    logic [9:0]  exp_bytes[$];   // {sof, eof, data}
    logic [19:0] exp_stat[$];    // {crc_ok, len_ok, rx_err, good, len}
    logic        exp_g13[$];
    logic [7:0]  body[$];
    logic [19:0] last_stat;

    always #5 Clk = ~Clk;

    eth_rx_fcs_check dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .gmii_rx_dv (dv),
        .gmii_rx_er (er),
        .gmii_rxd   (rxd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eof      (m_eof),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .len_ok     (len_ok),
        .rx_err     (rx_err),
        .frame_good (frame_good),
        .frame_len  (frame_len)
    );

    eth_rx_fcs_check #(.MIN_LEN(13)) dut13 (
        .Clk        (Clk),
        .Reset      (Reset),
        .gmii_rx_dv (dv),
        .gmii_rx_er (er),
        .gmii_rxd   (rxd),
        .m_valid    (v13),
        .m_data     (d13),
        .m_sof      (sof13),
        .m_eof      (eof13),
        .frame_done (fd13),
        .crc_ok     (crc13),
        .len_ok     (len13),
        .rx_err     (err13),
        .frame_good (good13),
        .frame_len  (flen13)
    );

    // Reference reflected CRC32 (poly EDB88320), one byte at a time.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Monitor: every output event is compared against the scoreboard.
    always @(negedge Clk) begin
        logic [9:0]  eb;
        logic [19:0] es;
        logic        eg;
        if (m_valid) begin
            checks++;
            assert (exp_bytes.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_byte got=%h expected=none", m_data);
            end
            if (exp_bytes.size() != 0) begin
                eb = exp_bytes.pop_front();
                checks++;
                assert ({m_sof, m_eof, m_data} === eb) else begin
                    failures++;
                    $error("FAIL byte got={sof,eof,data}=%h expected=%h", {m_sof, m_eof, m_data}, eb);
                end
            end
        end else begin
            checks++;
            assert ({m_sof, m_eof, m_data} === 10'd0) else begin
                failures++;
                $error("FAIL idle_zero got=%h expected=000", {m_sof, m_eof, m_data});
            end
        end
        if (frame_done) begin
            n_done++;
            checks++;
            assert (exp_stat.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_frame_done got=1 expected=0");
            end
            if (exp_stat.size() != 0) begin
                es = exp_stat.pop_front();
                checks++;
                assert ({crc_ok, len_ok, rx_err, frame_good, frame_len} === es) else begin
                    failures++;
                    $error("FAIL status got=%h expected=%h",
                           {crc_ok, len_ok, rx_err, frame_good, frame_len}, es);
                end
            end
        end
        if (fd13) begin
            checks++;
            assert (exp_g13.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_frame_done13 got=1 expected=0");
            end
            if (exp_g13.size() != 0) begin
                eg = exp_g13.pop_front();
                checks++;
                assert (good13 === eg) else begin
                    failures++;
                    $error("FAIL frame_good13 got=%b expected=%b", good13, eg);
                end
            end
        end
    end

    task automatic drive(input logic d_v, input logic e_r, input logic [7:0] d);
        @(posedge Clk);
        #1;
        dv  = d_v;
        er  = e_r;
        rxd = d;
    endtask

    // Scoreboard entries for the frame currently held in body.
    task automatic push_expect(input int er_idx);
        int          n;
        logic [31:0] c;
        logic        c_ok, l_ok, l13, e;
        logic [15:0] len;
        n = body.size();
        for (int k = 0; k + 5 <= n; k++) begin
            exp_bytes.push_back({(k == 0), (k == n - 5), body[k]});
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, body[i]);
        c_ok = (c == 32'hDEBB20E3);
        l_ok = (n >= 64) && (n <= 1518);
        l13  = (n >= 13) && (n <= 1518);
        e    = (er_idx >= 0) && (er_idx < n);
        len  = (n < 4) ? 16'd0 : 16'(n - 4);
        last_stat = {c_ok, l_ok, e, c_ok & l_ok & ~e, len};
        exp_stat.push_back(last_stat);
        exp_g13.push_back(c_ok & l13 & ~e);
    endtask

    // Preamble, SFD, body, then one dv-low gap cycle.
    task automatic send_frame(input int npre, input int er_idx);
        push_expect(er_idx);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < body.size(); i++) drive(1'b1, (i == er_idx), body[i]);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic make_frame(input int n_payload, input int seed);
        logic [31:0] c;
        body.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n_payload; i++) begin
            body.push_back(8'((i * 7 + seed) & 255));
            c = crc_upd(c, body[i]);
        end
        c = ~c;
        body.push_back(c[7:0]);
        body.push_back(c[15:8]);
        body.push_back(c[23:16]);
        body.push_back(c[31:24]);
    endtask

    task automatic set_test_frame(input logic [7:0] last);
        logic [7:0] t[13];
        t = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, last};
        body.delete();
        foreach (t[i]) body.push_back(t[i]);
    endtask

    // Idle until every expected event has been seen (bounded), then confirm.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_bytes.size() + exp_stat.size() + exp_g13.size()) != 0 && n < 40) begin
            drive(1'b0, 1'b0, 8'h00);
            n++;
        end
        repeat (4) drive(1'b0, 1'b0, 8'h00);
        checks++;
        assert ((exp_bytes.size() + exp_stat.size() + exp_g13.size()) == 0) else begin
            failures++;
            $error("FAIL %s_drain got=%0d pending expected=0",
                   tag, exp_bytes.size() + exp_stat.size() + exp_g13.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [7:0] mid[6];

        // Reset with dv already high (mid-frame traffic).
        Reset = 1'b1;
        dv = 1'b1; er = 1'b0; rxd = 8'h37;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        assert ({m_valid, m_sof, m_eof, m_data, frame_done} === 12'd0) else begin
            failures++;
            $error("FAIL reset_stream got=%h expected=000", {m_valid, m_sof, m_eof, m_data, frame_done});
        end
        checks++;
        assert ({crc_ok, len_ok, rx_err, frame_good, frame_len} === 20'd0) else begin
            failures++;
            $error("FAIL reset_status got=%h expected=00000", {crc_ok, len_ok, rx_err, frame_good, frame_len});
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Mid-frame bytes out of reset, including a 55/D5 pair: must be dropped.
        mid = '{8'h37, 8'h55, 8'h55, 8'hD5, 8'h10, 8'h11};
        foreach (mid[i]) drive(1'b1, 1'b0, mid[i]);
        drain("dv_from_reset");
        checks++;
        assert (n_done == 0) else begin
            failures++;
            $error("FAIL dv_from_reset_done got=%0d expected=0", n_done);
        end

        // Good frame "123456789" with its FCS.
        set_test_frame(8'hCB);
        send_frame(7, -1);
        drain("good");
        checks++;
        assert ({crc_ok, len_ok, rx_err, frame_good, frame_len} === last_stat) else begin
            failures++;
            $error("FAIL status_hold got=%h expected=%h", {crc_ok, len_ok, rx_err, frame_good, frame_len}, last_stat);
        end

        // Corrupt last FCS byte.
        set_test_frame(8'hCA);
        send_frame(7, -1);
        drain("bad_fcs");

        // 64-byte frame, rx_er on byte 10.
        make_frame(60, 3);
        send_frame(7, 10);
        drain("err64");

        // Preamble broken by AA: dropped.
        d0 = n_done;
        mid = '{8'h55, 8'h55, 8'hAA, 8'h55, 8'h55, 8'hD5};
        foreach (mid[i]) drive(1'b1, 1'b0, mid[i]);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
        drive(1'b0, 1'b0, 8'h00);
        drain("aa_preamble");
        checks++;
        assert (n_done == d0) else begin
            failures++;
            $error("FAIL aa_preamble_done got=%0d expected=%0d", n_done, d0);
        end

        // dv drops during preamble.
        d0 = n_done;
        repeat (3) drive(1'b1, 1'b0, 8'h55);
        drive(1'b0, 1'b0, 8'h00);
        drain("dv_low_preamble");
        checks++;
        assert (n_done == d0) else begin
            failures++;
            $error("FAIL dv_low_preamble_done got=%0d expected=%0d", n_done, d0);
        end

        // Runt: three bytes after SFD.
        body.delete();
        body.push_back(8'hA1); body.push_back(8'hA2); body.push_back(8'hA3);
        send_frame(1, -1);
        drain("runt");

        // Back-to-back frames with a single-cycle gap.
        d0 = n_done;
        set_test_frame(8'hCB);
        send_frame(7, -1);
        make_frame(70, 11);
        send_frame(3, -1);
        drain("b2b");
        checks++;
        assert (n_done == d0 + 2) else begin
            failures++;
            $error("FAIL b2b_done got=%0d expected=%0d", n_done - d0, 2);
        end

        // Reset while payload byte 20 would be driven. Bytes 0..12 are already out
        // (6-cycle latency); byte 13 is killed by the reset before it is sampled here.
        d0 = n_done;
        make_frame(60, 29);
        for (int k = 0; k <= 12; k++) exp_bytes.push_back({(k == 0), 1'b0, body[k]});
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, body[i]);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        dv = 1'b0;
        #1;
        checks++;
        assert ({m_valid, m_eof, frame_done, crc_ok} === 4'd0) else begin
            failures++;
            $error("FAIL reset_mid got=%h expected=0", {m_valid, m_eof, frame_done, crc_ok});
        end
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        drain("reset_mid");
        checks++;
        assert (n_done == d0) else begin
            failures++;
            $error("FAIL reset_mid_done got=%0d expected=%0d", n_done, d0);
        end

        // Next frame after reset decodes normally.
        set_test_frame(8'hCB);
        send_frame(7, -1);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
